// File: rtl/mux_serial_sequencer_pkg.sv
// Shared types and parameter helpers for the mux serial sequencer slice.
package mux_serial_sequencer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_SEL_W = $clog2(DEFAULT_WIDTH);

    // Width must be a power of two and the select exactly wide enough to address it.
    function automatic bit params_ok(input int width, input int sel_w);
        return (width >= 2) && ((width & (width - 1)) == 0) && (sel_w == $clog2(width));
    endfunction

endpackage

// File: rtl/mux_serial_sequencer_if.sv
// Load and serial-stream handshake bundle between the sequencer and its neighbours.
interface mux_serial_sequencer_if
    import mux_serial_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             abort;
    logic             ser_valid;
    logic             ser_data;
    logic             ser_last;
    logic             ser_ready;

    modport master (
        output load_valid, load_data, abort, ser_ready,
        input  load_ready, ser_valid, ser_data, ser_last
    );

    modport slave (
        input  load_valid, load_data, abort, ser_ready,
        output load_ready, ser_valid, ser_data, ser_last
    );

endinterface

// File: rtl/mux_serial_sequencer_sel_step_counter.sv
// Select counter: parks at START, steps toward END on enable, flags the terminal value.
module sel_step_counter
    import mux_serial_sequencer_pkg::*;
#(
    parameter int SEL_W     = DEFAULT_SEL_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    output logic [SEL_W-1:0] count,
    output logic             at_end
);

    localparam logic [SEL_W-1:0] START = MSB_FIRST ? '1 : '0;
    localparam logic [SEL_W-1:0] END   = MSB_FIRST ? '0 : '1;

    assign at_end = (count == END);

    // Stepping is blocked at END so the select can never wrap inside a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= START;
        end else if (load) begin
            count <= START;
        end else if (en && !at_end) begin
            count <= MSB_FIRST ? (count - 1'b1) : (count + 1'b1);
        end
    end

endmodule

// File: rtl/mux_serial_sequencer.sv
// Parallel-to-serial front end: holds a word on the mux inputs and walks the select across it.
module mux_serial_sequencer
    import mux_serial_sequencer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int SEL_W     = DEFAULT_SEL_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mux_serial_sequencer_if.slave   bus,
    output logic [WIDTH-1:0]        mux_in,
    output logic [SEL_W-1:0]        mux_sel,
    input  logic                    mux_out,
    output logic                    busy
);

    generate
        if (!params_ok(WIDTH, SEL_W)) begin : g_bad_params
            $error("mux_serial_sequencer: WIDTH must be a power of two >= 2 and SEL_W = clog2(WIDTH)");
        end
    endgenerate

    seq_state_e state_q;
    seq_state_e state_d;
    logic       capture;
    logic       load_sel;
    logic       step_sel;
    logic       at_end;
    logic       beat;

    assign beat = (state_q == RUN) && bus.ser_ready;

    // Abort wins over a last-beat reload, so readiness is withheld while it is raised in RUN.
    assign bus.load_ready = (state_q == IDLE) ||
                            ((state_q == RUN) && bus.ser_ready && at_end && !bus.abort);
    assign bus.ser_valid  = (state_q == RUN);
    assign bus.ser_last   = (state_q == RUN) && at_end;
    assign bus.ser_data   = mux_out;
    assign busy           = (state_q == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        load_sel = 1'b0;
        step_sel = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.load_valid) begin
                    capture  = 1'b1;
                    load_sel = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    load_sel = 1'b1;
                    state_d  = IDLE;
                end else if (beat && at_end) begin
                    // A word waiting at the last beat is taken with no bubble.
                    load_sel = 1'b1;
                    if (bus.load_valid) begin
                        capture = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (beat) begin
                    step_sel = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_in <= '0;
        end else if (capture) begin
            mux_in <= bus.load_data;
        end
    end

    sel_step_counter #(
        .SEL_W     (SEL_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_sel_step_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load_sel),
        .en     (step_sel),
        .count  (mux_sel),
        .at_end (at_end)
    );

endmodule

// File: tb/tb_mux_serial_sequencer.sv
// Drives an LSB-first and an MSB-first sequencer with the same stimulus and checks both against a bit-queue model.
module tb_mux_serial_sequencer;
    import mux_serial_sequencer_pkg::*;

    localparam int WIDTH = 16;
    localparam int SEL_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_serial_sequencer_if #(.WIDTH(WIDTH)) lsb_bus ();
    mux_serial_sequencer_if #(.WIDTH(WIDTH)) msb_bus ();

    logic [WIDTH-1:0] lsb_mux_in, msb_mux_in;
    logic [SEL_W-1:0] lsb_mux_sel, msb_mux_sel;
    logic             lsb_mux_out, msb_mux_out;
    logic             lsb_busy, msb_busy;

    // The 16:1 bit-select mux that sits beside each sequencer.
    assign lsb_mux_out = lsb_mux_in[lsb_mux_sel];
    assign msb_mux_out = msb_mux_in[msb_mux_sel];

    mux_serial_sequencer #(.WIDTH(WIDTH), .SEL_W(SEL_W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (lsb_bus.slave),
        .mux_in  (lsb_mux_in),
        .mux_sel (lsb_mux_sel),
        .mux_out (lsb_mux_out),
        .busy    (lsb_busy)
    );

    mux_serial_sequencer #(.WIDTH(WIDTH), .SEL_W(SEL_W), .MSB_FIRST(1'b1)) dut_msb (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (msb_bus.slave),
        .mux_in  (msb_mux_in),
        .mux_sel (msb_mux_sel),
        .mux_out (msb_mux_out),
        .busy    (msb_busy)
    );

    // Model: queue of emission positions still owed for the current word (0 = first bit out).
    int               pos_q[$];
    logic [WIDTH-1:0] model_word;
    int               accepted;
    int               errors;
    int               checks;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkDut(input string name, input bit msb, input bit exp_lr,
                            input logic lr, input logic sv, input logic sd, input logic sl,
                            input logic bz, input logic [WIDTH-1:0] mi, input logic [SEL_W-1:0] ms);
        bit exp_valid;
        int k;
        int exp_sel;
        exp_valid = (pos_q.size() > 0);
        k         = exp_valid ? pos_q[0] : 0;
        exp_sel   = msb ? (WIDTH - 1 - k) : k;
        checkOutput({name, ".load_ready"}, 32'(lr), 32'(exp_lr));
        checkOutput({name, ".ser_valid"},  32'(sv), 32'(exp_valid));
        checkOutput({name, ".busy"},       32'(bz), 32'(exp_valid));
        checkOutput({name, ".ser_last"},   32'(sl), 32'(pos_q.size() == 1));
        checkOutput({name, ".mux_in"},     32'(mi), 32'(model_word));
        checkOutput({name, ".mux_sel"},    32'(ms), 32'(exp_sel));
        if (exp_valid) begin
            checkOutput({name, ".ser_data"}, 32'(sd), 32'(model_word[exp_sel]));
        end
    endtask

    // One clock of stimulus: drive at the falling edge, check just after, advance the model.
    task automatic applyStimulus(input bit rst_v, input bit lv, input logic [WIDTH-1:0] d,
                                 input bit ab, input bit sr);
        bit exp_lr;
        @(negedge clk);
        rst_n              = !rst_v;
        lsb_bus.load_valid = lv;
        lsb_bus.load_data  = d;
        lsb_bus.abort      = ab;
        lsb_bus.ser_ready  = sr;
        msb_bus.load_valid = lv;
        msb_bus.load_data  = d;
        msb_bus.abort      = ab;
        msb_bus.ser_ready  = sr;
        #1;
        if (rst_v) begin
            pos_q.delete();
            model_word = '0;
        end
        exp_lr = (pos_q.size() == 0) || ((pos_q.size() == 1) && sr && !ab);
        checkDut("lsb", 1'b0, exp_lr, lsb_bus.load_ready, lsb_bus.ser_valid, lsb_bus.ser_data,
                 lsb_bus.ser_last, lsb_busy, lsb_mux_in, lsb_mux_sel);
        checkDut("msb", 1'b1, exp_lr, msb_bus.load_ready, msb_bus.ser_valid, msb_bus.ser_data,
                 msb_bus.ser_last, msb_busy, msb_mux_in, msb_mux_sel);
        if (!rst_v) begin
            if (pos_q.size() > 0) begin
                if (ab) pos_q.delete();
                else if (sr) void'(pos_q.pop_front());
            end
            if (exp_lr && lv) begin
                model_word = d;
                for (int k = 0; k < WIDTH; k++) pos_q.push_back(k);
                accepted++;
            end
        end
    endtask

    initial begin
        int start_count;
        errors   = 0;
        checks   = 0;
        accepted = 0;
        model_word = '0;

        // Reset held with random inputs, then released with no load offered.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 16'($urandom), 1'($urandom), 1'($urandom));

        // Single word at full rate.
        applyStimulus(1'b0, 1'b1, 16'hA5C3, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Same word under 1,0,0 backpressure.
        applyStimulus(1'b0, 1'b1, 16'hA5C3, 1'b0, 1'b1);
        for (int i = 0; i < 52; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, (i % 3) == 0);

        // Back-to-back words with load_valid held.
        start_count = accepted;
        for (int i = 0; i < 36; i++)
            applyStimulus(1'b0, (accepted - start_count) < 2,
                          (accepted == start_count) ? 16'hFFFF : 16'h0001, 1'b0, 1'b1);

        // Abort on the fifth beat with a word pending, accepted the cycle after.
        applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Endpoint-heavy word for the MSB-first instance.
        applyStimulus(1'b0, 1'b1, 16'h8001, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Random traffic, including aborts, last-beat reloads and mid-word resets.
        for (int i = 0; i < 2000; i++)
            applyStimulus($urandom_range(0, 299) == 0, 1'($urandom),
                          ($urandom_range(0, 7) == 0) ? 16'h8001 : 16'($urandom),
                          $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
